// File: rtl/mux_4a2_l1_pkg.sv
// Shared L1 lane definitions used by the L1 mux and the L1/L2 demuxes.
package mux_4a2_l1_pkg;

    localparam int N_LANES_IN  = 4;
    localparam int N_LANES_OUT = 2;
    localparam int WIDTH_DEF   = 8;

    typedef struct packed {
        logic                 valid;
        logic [WIDTH_DEF-1:0] data;
    } lane_t;

endpackage

// File: rtl/mux_pair_reg.sv
// Two-lane valid/data register with load enable; invalid lanes optionally
// load zero data so the outputs never expose stale words.
module mux_pair_reg
    import mux_4a2_l1_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int MASK_INVALID = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [N_LANES_OUT-1:0] valid_d,
    input  logic [WIDTH-1:0]       data_d [N_LANES_OUT],
    output logic [N_LANES_OUT-1:0] valid_q,
    output logic [WIDTH-1:0]       data_q [N_LANES_OUT]
);

    logic [WIDTH-1:0] data_m [N_LANES_OUT];

    always_comb begin
        for (int i = 0; i < N_LANES_OUT; i++) begin
            data_m[i] = data_d[i];
            if ((MASK_INVALID != 0) && !valid_d[i]) begin
                data_m[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N_LANES_OUT; i++) begin
                data_q[i] <= '0;
            end
        end else if (load) begin
            valid_q <= valid_d;
            for (int i = 0; i < N_LANES_OUT; i++) begin
                data_q[i] <= data_m[i];
            end
        end
    end

endmodule

// File: rtl/mux_4a2_l1.sv
// L1 4-to-2 recombining mux: samples four lanes every other clk_2f edge and
// emits them as two consecutive lane pairs, order chosen by selectorL1.
module mux_4a2_l1
    import mux_4a2_l1_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int MASK_INVALID = 1
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             selectorL1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             valid3,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    output logic             validout0,
    output logic             validout1,
    output logic [WIDTH-1:0] dataout0,
    output logic [WIDTH-1:0] dataout1,
    output logic             pair_sel
);

    logic                   phase_q;
    logic                   sel_q;
    logic                   pair_sel_q;
    logic                   sel_eff;

    logic [N_LANES_IN-1:0]  vin;
    logic [WIDTH-1:0]       din [N_LANES_IN];

    logic [N_LANES_OUT-1:0] first_v;
    logic [N_LANES_OUT-1:0] second_v;
    logic [WIDTH-1:0]       first_d  [N_LANES_OUT];
    logic [WIDTH-1:0]       second_d [N_LANES_OUT];

    logic [N_LANES_OUT-1:0] hold_v_q;
    logic [WIDTH-1:0]       hold_d_q [N_LANES_OUT];
    logic [N_LANES_OUT-1:0] out_v_d;
    logic [WIDTH-1:0]       out_d_d  [N_LANES_OUT];
    logic [N_LANES_OUT-1:0] out_v_q;
    logic [WIDTH-1:0]       out_d_q  [N_LANES_OUT];

    assign vin    = {valid3, valid2, valid1, valid0};
    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            phase_q    <= 1'b0;
            sel_q      <= 1'b0;
            pair_sel_q <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                sel_q      <= selectorL1;
                pair_sel_q <= 1'b0;
            end else begin
                pair_sel_q <= 1'b1;
            end
        end
    end

    // Order in force for the group in flight; selectorL1 only counts at phase 0.
    assign sel_eff = phase_q ? sel_q : selectorL1;

    always_comb begin
        for (int i = 0; i < N_LANES_OUT; i++) begin
            first_v[i]  = sel_eff ? vin[i]     : vin[i + 2];
            first_d[i]  = sel_eff ? din[i]     : din[i + 2];
            second_v[i] = sel_eff ? vin[i + 2] : vin[i];
            second_d[i] = sel_eff ? din[i + 2] : din[i];
            out_v_d[i]  = phase_q ? hold_v_q[i] : first_v[i];
            out_d_d[i]  = phase_q ? hold_d_q[i] : first_d[i];
        end
    end

    mux_pair_reg #(
        .WIDTH        (WIDTH),
        .MASK_INVALID (MASK_INVALID)
    ) u_hold (
        .clk     (clk_2f),
        .rst     (reset),
        .load    (~phase_q),
        .valid_d (second_v),
        .data_d  (second_d),
        .valid_q (hold_v_q),
        .data_q  (hold_d_q)
    );

    mux_pair_reg #(
        .WIDTH        (WIDTH),
        .MASK_INVALID (MASK_INVALID)
    ) u_out (
        .clk     (clk_2f),
        .rst     (reset),
        .load    (1'b1),
        .valid_d (out_v_d),
        .data_d  (out_d_d),
        .valid_q (out_v_q),
        .data_q  (out_d_q)
    );

    assign validout0 = out_v_q[0];
    assign validout1 = out_v_q[1];
    assign dataout0  = out_d_q[0];
    assign dataout1  = out_d_q[1];
    assign pair_sel  = pair_sel_q;

endmodule

// File: tb/tb_mux_4a2_l1.sv
// Bench for mux_4a2_l1: table-driven groups scored through an expected-pair
// queue, plus hand sequences for mid-group input changes and reset.
module tb_mux_4a2_l1;

    logic       clk_2f;
    logic       reset;
    logic       selectorL1;
    logic       valid0, valid1, valid2, valid3;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       validout0, validout1;
    logic [7:0] dataout0, dataout1;
    logic       pair_sel;

    mux_4a2_l1 #(.WIDTH(8), .MASK_INVALID(1)) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .selectorL1 (selectorL1),
        .valid0     (valid0),
        .valid1     (valid1),
        .valid2     (valid2),
        .valid3     (valid3),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .validout0  (validout0),
        .validout1  (validout1),
        .dataout0   (dataout0),
        .dataout1   (dataout1),
        .pair_sel   (pair_sel)
    );

    typedef struct packed {
        logic            sel;
        logic [3:0]      v;
        logic [3:0][7:0] d;
    } vec_t;

    typedef struct packed {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ps;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk_2f = 1'b0;
        forever #5 clk_2f = ~clk_2f;
    end

    function automatic exp_t actual();
        exp_t a;
        a.v0 = validout0;
        a.v1 = validout1;
        a.d0 = dataout0;
        a.d1 = dataout1;
        a.ps = pair_sel;
        return a;
    endfunction

    function automatic exp_t mk_pair(vec_t g, int base, logic ps);
        exp_t e;
        e.v0 = g.v[base];
        e.v1 = g.v[base + 1];
        e.d0 = g.v[base]     ? g.d[base]     : 8'h00;
        e.d1 = g.v[base + 1] ? g.d[base + 1] : 8'h00;
        e.ps = ps;
        return e;
    endfunction

    task automatic drive(vec_t g);
        selectorL1 = g.sel;
        {valid3, valid2, valid1, valid0} = g.v;
        data_in0 = g.d[0];
        data_in1 = g.d[1];
        data_in2 = g.d[2];
        data_in3 = g.d[3];
    endtask

    task automatic push_group(vec_t g);
        sb.push_back(mk_pair(g, g.sel ? 0 : 2, 1'b0));
        sb.push_back(mk_pair(g, g.sel ? 2 : 0, 1'b1));
    endtask

    task automatic check_now(string name, exp_t e);
        exp_t a;
        a = actual();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got v=%b%b d=%h,%h ps=%b want v=%b%b d=%h,%h ps=%b",
                     name, a.v0, a.v1, a.d0, a.d1, a.ps, e.v0, e.v1, e.d0, e.d1, e.ps);
        end
    endtask

    task automatic step(string name);
        exp_t e;
        @(posedge clk_2f);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_now(name, e);
        end
    endtask

    function automatic vec_t mk_vec(logic s, logic [3:0] v, logic [7:0] a, logic [7:0] b,
                                    logic [7:0] c, logic [7:0] d);
        vec_t g;
        g.sel  = s;
        g.v    = v;
        g.d[0] = a;
        g.d[1] = b;
        g.d[2] = c;
        g.d[3] = d;
        return g;
    endfunction

    initial begin
        vec_t g;
        exp_t zero;
        zero = '0;

        tbl[0] = mk_vec(1'b1, 4'b1111, 8'h10, 8'h08, 8'h1F, 8'h11);
        tbl[1] = mk_vec(1'b0, 4'b1111, 8'h10, 8'h08, 8'h1F, 8'h11);
        tbl[2] = mk_vec(1'b1, 4'b1001, 8'h23, 8'h09, 8'h2D, 8'h14);
        for (int k = 0; k < 4; k++) begin
            tbl[3 + k] = mk_vec(k[0] ? 1'b0 : 1'b1, (k == 2) ? 4'b0000 : 4'b1111,
                                8'(8'h40 + 4 * k), 8'(8'h41 + 4 * k),
                                8'(8'h42 + 4 * k), 8'(8'h43 + 4 * k));
        end

        reset = 1'b1;
        drive(mk_vec(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00));
        #12;
        check_now("reset_state", zero);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            push_group(tbl[i]);
            step($sformatf("vec%0d_first", i));
            step($sformatf("vec%0d_second", i));
        end

        // Inputs disturbed between the phase-0 and phase-1 edges.
        drive(tbl[0]);
        push_group(tbl[0]);
        step("aa_first");
        data_in0 = 8'hAA;
        data_in1 = 8'hAA;
        data_in2 = 8'hAA;
        data_in3 = 8'hAA;
        step("aa_second_unaffected");
        g = mk_vec(1'b1, 4'b1111, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
        push_group(g);
        step("aa_next_first");
        step("aa_next_second");

        // Reset while the second pair is still held.
        g = mk_vec(1'b0, 4'b1111, 8'h55, 8'h66, 8'h77, 8'h88);
        drive(g);
        push_group(g);
        step("rst_mid_first");
        #2;
        reset = 1'b1;
        #1;
        check_now("rst_async_clear", zero);
        void'(sb.pop_front());
        @(posedge clk_2f);
        #1;
        check_now("rst_held", zero);
        #1;
        reset = 1'b0;
        g = mk_vec(1'b1, 4'b0110, 8'h31, 8'h32, 8'h33, 8'h34);
        drive(g);
        push_group(g);
        step("rst_restart_first");
        step("rst_restart_second");

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
